// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//
// Iterative unsigned multiply/divide unit placed between register-file operand
// read and register-file write-back. One operation is accepted at a time. Each
// operation runs one iteration per clock, and the unit holds the core with
// busy while it works. On completion it issues a single-cycle write strobe,
// together with the destination index and the result, to the register file.
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-high reset
//   start             request strobe, sampled only while idle
//   op                00 MUL (low), 01 MULHU (high), 10 DIVU, 11 REMU
//   operand_a         multiplicand / dividend
//   operand_b         multiplier / divisor
//   dest_reg          destination register index
//   busy              high from the accepting edge through the DONE state
//   done              one-cycle completion pulse
//   result            final result, valid with done and held afterwards
//   write_register_d  register-file write enable (same as done)
//   register_d        latched destination index, valid with done
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [DATA_WIDTH-1:0]     operand_a,
    input  logic [DATA_WIDTH-1:0]     operand_b,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      write_register_d,
    output logic [REG_ADDR_WIDTH-1:0] register_d
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_reg, state_next;

    // Latched request
    logic [1:0]                op_reg;
    logic [DATA_WIDTH-1:0]     a_reg;
    logic [DATA_WIDTH-1:0]     b_reg;
    logic [REG_ADDR_WIDTH-1:0] dest_reg_reg;

    // Iteration state
    logic [CW-1:0]             counter_reg;
    logic [2*DATA_WIDTH-1:0]   product_reg;
    logic [DATA_WIDTH-1:0]     quotient_reg;
    logic [DATA_WIDTH:0]       remainder_reg;

    // Registered outputs
    logic                      done_reg;
    logic [DATA_WIDTH-1:0]     result_reg;
    logic [REG_ADDR_WIDTH-1:0] register_d_reg;

    logic accept;
    logic div_by_zero;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    assign div_by_zero = op[1] && (operand_b == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    // A zero divisor has a fixed answer, so skip the iterations.
                    state_next = div_by_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (counter_reg == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);

    // -------------------------------------------------------------------------
    // Iteration datapath
    // -------------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] addend;
    logic [CW-1:0]           div_bit_idx;
    logic [DATA_WIDTH:0]     shifted_rem;
    logic [DATA_WIDTH:0]     trial_diff;
    logic                    trial_fits;
    logic [DATA_WIDTH-1:0]   final_result;

    assign addend = {{DATA_WIDTH{1'b0}}, a_reg} << counter_reg;

    // The dividend is consumed MSB-first while the counter runs upward.
    assign div_bit_idx = LAST_ITER - counter_reg;
    assign shifted_rem = {remainder_reg[DATA_WIDTH-1:0], a_reg[div_bit_idx]};
    assign trial_diff  = shifted_rem - {1'b0, b_reg};
    assign trial_fits  = (shifted_rem >= {1'b0, b_reg});

    always_comb begin
        final_result = '0;
        case (op_reg)
            OP_MUL:   final_result = product_reg[DATA_WIDTH-1:0];
            OP_MULHU: final_result = product_reg[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIVU:  final_result = quotient_reg;
            default:  final_result = remainder_reg[DATA_WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            dest_reg_reg  <= '0;
            counter_reg   <= '0;
            product_reg   <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else if (accept) begin
            op_reg       <= op;
            a_reg        <= operand_a;
            b_reg        <= operand_b;
            dest_reg_reg <= dest_reg;
            counter_reg  <= '0;
            product_reg  <= '0;
            if (div_by_zero) begin
                // Preload the divide-by-zero answers so DONE reads them as usual.
                quotient_reg  <= '1;
                remainder_reg <= {1'b0, operand_a};
            end else begin
                quotient_reg  <= '0;
                remainder_reg <= '0;
            end
        end else if (state_reg == BUSY) begin
            counter_reg <= counter_reg + 1'b1;
            if (!op_reg[1]) begin
                if (b_reg[counter_reg]) begin
                    product_reg <= product_reg + addend;
                end
            end else begin
                remainder_reg <= trial_fits ? trial_diff : shifted_rem;
                quotient_reg  <= {quotient_reg[DATA_WIDTH-2:0], trial_fits};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Write-back outputs, registered out of the DONE state so the register
    // file sees clean flop outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_reg       <= 1'b0;
            result_reg     <= '0;
            register_d_reg <= '0;
        end else begin
            done_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                result_reg     <= final_result;
                register_d_reg <= dest_reg_reg;
            end
        end
    end

    assign done             = done_reg;
    assign write_register_d = done_reg;
    assign result           = result_reg;
    assign register_d       = register_d_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//
// Directed-vector bench for mul_div_unit. Inputs are driven and outputs are
// sampled on the falling clock edge. Edge counts are taken relative to the
// accepting rising edge E0.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  dest_reg;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        write_register_d;
    logic [4:0]  register_d;

    int checks_total;
    int checks_passed;

    mul_div_unit #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .op               (op),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .dest_reg         (dest_reg),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .write_register_d (write_register_d),
        .register_d       (register_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one operation (called on a falling edge) and check its completion.
    // With disturb set, start is pulsed with unrelated operands during BUSY
    // and again during the DONE state; both pulses must be ignored.
    task automatic run_op(input string tag, input logic [1:0] op_i,
                          input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic [4:0] dest_i, input logic [31:0] exp_res,
                          input int exp_lat, input bit disturb);
        int n;
        int busy_bad;
        bit seen;
        start     = 1'b1;
        op        = op_i;
        operand_a = a_i;
        operand_b = b_i;
        dest_reg  = dest_i;
        next_cycle();                       // E0
        start    = 1'b0;
        n        = 0;
        busy_bad = 0;
        seen     = 1'b0;
        while (n < 100) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_bad++;
            start = 1'b0;
            if (disturb && (n == 5 || n == exp_lat - 1)) begin
                start     = 1'b1;
                op        = 2'b00;
                operand_a = 32'd9;
                operand_b = 32'd9;
                dest_reg  = 5'd31;
            end
            next_cycle();
            n++;
        end
        start = 1'b0;
        $display("op=%0d a=0x%08h b=0x%08h dest=%0d -> result=0x%08h rd=%0d after %0d edges",
                 op_i, a_i, b_i, dest_i, result, register_d, n);
        check_value({tag, " done_seen"}, 64'(seen), 64'd1);
        check_value({tag, " latency"}, 64'(n), 64'(exp_lat));
        check_value({tag, " result"}, 64'(result), 64'(exp_res));
        check_value({tag, " register_d"}, 64'(register_d), 64'(dest_i));
        check_value({tag, " write_en"}, 64'(write_register_d), 64'd1);
        check_value({tag, " busy_in_done"}, 64'(busy), 64'd0);
        check_value({tag, " busy_while_running"}, 64'(busy_bad), 64'd0);
        next_cycle();
        check_value({tag, " done_pulse_width"}, 64'(done), 64'd0);
        check_value({tag, " write_en_after"}, 64'(write_register_d), 64'd0);
        check_value({tag, " result_held"}, 64'(result), 64'(exp_res));
        if (disturb) begin
            // A start accepted in DONE would show up as busy or a second done.
            for (int k = 0; k < 3; k++) begin
                check_value({tag, " no_second_accept"}, 64'({busy, done}), 64'd0);
                next_cycle();
            end
        end
    endtask

    initial begin
        int bad_done;
        int bad_after;
        checks_total  = 0;
        checks_passed = 0;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        dest_reg  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_value("reset busy", 64'(busy), 64'd0);
        check_value("reset done", 64'(done), 64'd0);
        check_value("reset write_en", 64'(write_register_d), 64'd0);
        check_value("reset result", 64'(result), 64'd0);
        check_value("reset register_d", 64'(register_d), 64'd0);
        reset = 1'b0;
        next_cycle();

        // 1: basic MUL
        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 33, 1'b0);
        // 2: high and low product of all-ones operands
        run_op("mulhu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("mul_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, 33, 1'b0);
        run_op("mul_shift", 2'b00, 32'h1234_5678, 32'h0000_0010, 5'd5, 32'h2345_6780, 33, 1'b0);
        run_op("mulhu_small", 2'b01, 32'h8000_0000, 32'd4, 5'd6, 32'd2, 33, 1'b0);
        // 3: divide and remainder
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd9, 32'd14, 33, 1'b0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd9, 32'd2, 33, 1'b0);
        run_op("divu_max_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 5'd10, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("remu_7_100", 2'b11, 32'd7, 32'd100, 5'd11, 32'd7, 33, 1'b0);
        run_op("divu_big", 2'b10, 32'hF000_0000, 32'h0000_0003, 5'd12, 32'h5000_0000, 33, 1'b0);
        // 4: divide by zero
        run_op("divu_by0", 2'b10, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("remu_by0", 2'b11, 32'd5, 32'd0, 5'd14, 32'd5, 1, 1'b0);

        // 5: reset in the middle of a MUL aborts it without a write
        start     = 1'b1;
        op        = 2'b00;
        operand_a = 32'd11;
        operand_b = 32'd13;
        dest_reg  = 5'd7;
        next_cycle();
        start    = 1'b0;
        bad_done = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || write_register_d) bad_done++;
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bad_after = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || write_register_d) bad_done++;
            if (busy || result != 32'd0 || register_d != 5'd0) bad_after++;
            next_cycle();
        end
        $display("reset abort: spurious_done=%0d bad_idle_cycles=%0d", bad_done, bad_after);
        check_value("abort no_write", 64'(bad_done), 64'd0);
        check_value("abort idle_after_reset", 64'(bad_after), 64'd0);
        run_op("mul_3x4_after_reset", 2'b00, 32'd3, 32'd4, 5'd8, 32'd12, 33, 1'b0);

        // 6: start pulses during BUSY and DONE are ignored
        run_op("divu_50_5_disturbed", 2'b10, 32'd50, 32'd5, 5'd4, 32'd10, 33, 1'b1);
        run_op("mul_after_disturb", 2'b00, 32'd9, 32'd9, 5'd15, 32'd81, 33, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
